// File: rtl/distribuidor_fifo_if.sv
// Bundle between the distributor, its upstream FIFO and the four destination FIFOs.
// The slave view belongs to the distributor; the master view belongs to its environment.
interface distribuidor_fifo_if #(
  parameter int tamano_datos   = 10,
  parameter int ancho_contador = 8
);
  logic [tamano_datos-1:0]   fifo_data_out;
  logic                      fifo_empty;
  logic                      fifo_error;
  logic [3:0]                pausa;
  logic                      fifo_read_enable;
  logic [tamano_datos-1:0]   data_out;
  logic [3:0]                valid_out;
  logic [ancho_contador-1:0] enviados;
  logic [1:0]                estado;
  logic                      error_out;

  modport master (
    output fifo_data_out, fifo_empty, fifo_error, pausa,
    input  fifo_read_enable, data_out, valid_out, enviados, estado, error_out
  );

  modport slave (
    input  fifo_data_out, fifo_empty, fifo_error, pausa,
    output fifo_read_enable, data_out, valid_out, enviados, estado, error_out
  );
endinterface

// File: rtl/distribuidor_fifo.sv
// Drains the upstream FIFO and steers each word to one of four destinations by its two MSBs,
// with flow-state tracking, a forwarded-word counter and a sticky error latch.
module distribuidor_fifo #(
  parameter int tamano_datos    = 10,
  parameter int tamano_direcion = 3,
  parameter int ancho_contador  = 8
) (
  input  logic                clk,
  input  logic                reset,
  distribuidor_fifo_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    PAUSE  = 2'b10,
    ERROR  = 2'b11
  } estado_t;

  // The routing field needs two bits; the upstream address width only documents the source FIFO.
  if (tamano_datos < 2 || tamano_direcion < 1) begin : g_param_check
    $error("distribuidor_fifo: tamano_datos must be >= 2 and tamano_direcion >= 1");
  end

  estado_t                   estado_reg, estado_next;
  logic                      rd_pend_reg;
  logic [tamano_datos-1:0]   data_out_reg;
  logic [3:0]                valid_out_reg;
  logic [ancho_contador-1:0] enviados_reg;
  logic                      error_out_reg;

  logic                      pausa_any;
  logic                      read_en;
  logic                      push;
  logic [1:0]                dest_sel;
  logic [3:0]                push_oh;

  assign pausa_any = |bus.pausa;
  assign dest_sel  = bus.fifo_data_out[tamano_datos-1 -: 2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dest
    assign push_oh[gi] = push && (dest_sel == 2'(gi));
  end

  always_comb begin
    estado_next = estado_reg;
    read_en     = 1'b0;
    push        = 1'b0;

    read_en = (estado_reg == ACTIVE) && !bus.fifo_empty && !pausa_any;
    // A word arriving while the error is being taken (or afterwards) is dropped.
    push    = rd_pend_reg && !bus.fifo_error && (estado_reg != ERROR);

    case (estado_reg)
      IDLE: begin
        if (!bus.fifo_empty && !pausa_any) estado_next = ACTIVE;
      end
      ACTIVE: begin
        if (pausa_any)            estado_next = PAUSE;
        else if (bus.fifo_empty)  estado_next = IDLE;
      end
      PAUSE: begin
        if (!pausa_any) estado_next = bus.fifo_empty ? IDLE : ACTIVE;
      end
      default: estado_next = ERROR;
    endcase

    if (bus.fifo_error) estado_next = ERROR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_reg    <= IDLE;
      rd_pend_reg   <= 1'b0;
      data_out_reg  <= '0;
      valid_out_reg <= 4'b0000;
      enviados_reg  <= '0;
      error_out_reg <= 1'b0;
    end else begin
      estado_reg    <= estado_next;
      rd_pend_reg   <= read_en;
      valid_out_reg <= push_oh;
      if (push) data_out_reg <= bus.fifo_data_out;
      // Counts the strobe already on the outputs, so it trails valid_out by one edge.
      if (|valid_out_reg) enviados_reg <= enviados_reg + 1'b1;
      if (estado_next == ERROR) error_out_reg <= 1'b1;
    end
  end

  assign bus.fifo_read_enable = read_en;
  assign bus.data_out         = data_out_reg;
  assign bus.valid_out        = valid_out_reg;
  assign bus.enviados         = enviados_reg;
  assign bus.estado           = estado_reg;
  assign bus.error_out        = error_out_reg;

endmodule

// File: tb/tb_distribuidor_fifo.sv
// Bench for distribuidor_fifo: a queue models the upstream FIFO and a scoreboard
// holds every word in the order it must reach the destinations.
module tb_distribuidor_fifo;
  localparam int TD = 10;
  localparam int AC = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  distribuidor_fifo_if #(.tamano_datos(TD), .ancho_contador(AC)) bus ();

  distribuidor_fifo #(
    .tamano_datos(TD), .tamano_direcion(3), .ancho_contador(AC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [TD-1:0] up_q[$];
  logic [TD-1:0] exp_q[$];
  int cyc = 0;
  int rd_first = -1;
  int push_cnt = 0;
  int env_model = 0;
  int push_cyc_q[$];
  logic [TD-1:0] mon_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [TD-1:0] w);
    logic [3:0] r;
    r = 4'b0001 << w[TD-1 -: 2];
    return r;
  endfunction

  task automatic enq(input logic [TD-1:0] w);
    up_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Upstream FIFO: read data appears the cycle after the read enable is sampled.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.fifo_read_enable === 1'b1) begin
      chk("no_underflow", (up_q.size() > 0), 1);
      if (up_q.size() > 0) bus.fifo_data_out <= up_q.pop_front();
      if (rd_first < 0) rd_first = cyc;
    end
  end

  always @(negedge clk) bus.fifo_empty = (up_q.size() == 0);

  // Destination side: one line per push, checked against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (bus.valid_out !== 4'b0000) begin
      $display("push cyc=%0d dest=%b data=%h enviados=%0d", cyc, bus.valid_out, bus.data_out, bus.enviados);
      if (exp_q.size() == 0) begin
        chk("unexpected_push", bus.valid_out, 0);
      end else begin
        mon_w = exp_q.pop_front();
        chk("data", bus.data_out, mon_w);
        chk("dest", bus.valid_out, onehot(mon_w));
      end
      push_cnt++;
      env_model = (env_model + 1) % 256;
      push_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int pc_pause;
    int n;

    bus.pausa      = 4'b0000;
    bus.fifo_error = 1'b0;
    reset          = 1'b0;
    step(2);
    chk("rst_estado", bus.estado, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_enviados", bus.enviados, 0);
    chk("rst_error", bus.error_out, 0);
    chk("rst_rd_en", bus.fifo_read_enable, 0);
    reset = 1'b1;
    step(2);

    // One word to each destination, back to back.
    rd_first = -1;
    push_cyc_q.delete();
    enq(10'h000); enq(10'h155); enq(10'h2AA); enq(10'h3FF);
    drain(30, "t1_drain");
    step(3);
    chk("t1_count", push_cyc_q.size(), 4);
    if (push_cyc_q.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("t1_back2back", push_cyc_q[i] - push_cyc_q[i-1], 1);
      chk("t1_latency", push_cyc_q[0] - rd_first, 1);
    end
    chk("t1_enviados", bus.enviados, 4);
    chk("t1_estado", bus.estado, 0);

    // Pause destination 2 mid-stream.
    p0 = push_cnt;
    for (int i = 0; i < 8; i++) enq(10'h200 | 10'(i));
    n = 0;
    while (up_q.size() > 5 && n < 30) begin step(1); n++; end
    chk("t2_started", (up_q.size() <= 5), 1);
    bus.pausa = 4'b0100;
    #1;
    chk("t2_rd_drop", bus.fifo_read_enable, 0);
    pc_pause = push_cnt;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t2_estado_pause", bus.estado, 2);
      chk("t2_rd_blocked", bus.fifo_read_enable, 0);
    end
    chk("t2_inflight_le2", ((push_cnt - pc_pause) <= 2), 1);
    bus.pausa = 4'b0000;
    drain(40, "t2_drain");
    step(3);
    chk("t2_total", push_cnt - p0, 8);
    chk("t2_estado_idle", bus.estado, 0);
    chk("t2_enviados", bus.enviados, env_model);

    // Upstream error while streaming: nothing further may be pushed.
    p0 = push_cnt;
    for (int i = 0; i < 6; i++) enq(10'h100 | 10'(i));
    n = 0;
    while (push_cnt == p0 && n < 30) begin step(1); n++; end
    chk("t3_started", (push_cnt > p0), 1);
    bus.fifo_error = 1'b1;
    exp_q.delete();
    step(1);
    bus.fifo_error = 1'b0;
    chk("t3_estado", bus.estado, 3);
    chk("t3_error_out", bus.error_out, 1);
    chk("t3_rd_en", bus.fifo_read_enable, 0);
    step(6);
    chk("t3_estado_sticky", bus.estado, 3);
    chk("t3_error_sticky", bus.error_out, 1);
    chk("t3_rd_en_sticky", bus.fifo_read_enable, 0);
    chk("t3_valid", bus.valid_out, 0);
    chk("t3_enviados_frozen", bus.enviados, env_model);
    reset = 1'b0;
    #1;
    chk("t3_rst_estado", bus.estado, 0);
    chk("t3_rst_error", bus.error_out, 0);
    chk("t3_rst_enviados", bus.enviados, 0);
    chk("t3_rst_data", bus.data_out, 0);
    chk("t3_rst_valid", bus.valid_out, 0);
    up_q.delete();
    env_model = 0;
    step(2);
    reset = 1'b1;
    step(2);

    // 257 words: the counter wraps past 255.
    for (int i = 0; i < 257; i++) enq(10'($urandom_range(0, 1023)));
    drain(700, "t4_drain");
    step(3);
    chk("t4_enviados_wrap", bus.enviados, 1);

    // Asynchronous reset while a read is in flight.
    enq(10'h0AB); enq(10'h1CD); enq(10'h2EF); enq(10'h312);
    n = 0;
    while (up_q.size() > 3 && n < 30) begin step(1); n++; end
    chk("t5_inflight", up_q.size(), 3);
    #1;
    p0 = push_cnt;
    reset = 1'b0;
    exp_q.delete();
    up_q.delete();
    #1;
    chk("t5_estado", bus.estado, 0);
    chk("t5_valid", bus.valid_out, 0);
    chk("t5_enviados", bus.enviados, 0);
    chk("t5_data", bus.data_out, 0);
    chk("t5_rd_en", bus.fifo_read_enable, 0);
    env_model = 0;
    step(2);
    reset = 1'b1;
    step(4);
    chk("t5_no_push", push_cnt - p0, 0);
    rd_first = -1;
    push_cyc_q.delete();
    enq(10'h3C5);
    drain(20, "t5_drain");
    chk("t5_one_push", push_cyc_q.size(), 1);
    if (push_cyc_q.size() == 1) chk("t5_latency", push_cyc_q[0] - rd_first, 1);

    // Empty upstream with no pause: stays idle.
    step(3);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t6_idle", {bus.fifo_read_enable, bus.estado, bus.valid_out}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/distribuidor_fifo.md
Name: distribuidor_fifo

Overview:
- Downstream consumer of the 10-bit input FIFO.
- Pops words whenever the FIFO is non-empty and no destination is pausing.
- Routes each word to one of four destination FIFOs, selected by its two MSBs.
- Tracks flow state in a 4-state FSM, counts forwarded words, and latches upstream FIFO errors.

Parameters:
- tamano_datos, 10, word width; bits [tamano_datos-1:tamano_datos-2] select the destination.
- tamano_direcion, 3, address width of the upstream FIFO; informational only, no logic depends on it.
- ancho_contador, 8, width of the forwarded-word counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state.
- fifo_data_out  input  tamano_datos  upstream FIFO read data, valid the cycle after fifo_read_enable is sampled high.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_error  input  1  upstream FIFO overflow/underflow flag.
- pausa  input  4  per-destination almost_full; bit i=1 stops issuing reads.
- fifo_read_enable  output  1  pop request to the upstream FIFO.
- data_out  output  tamano_datos  registered forwarded word, shared by all destinations.
- valid_out  output  4  one-hot push strobe; bit i means data_out is for destination i.
- enviados  output  ancho_contador  total words forwarded, wraps.
- estado  output  2  FSM state: IDLE=00, ACTIVE=01, PAUSE=10, ERROR=11.
- error_out  output  1  sticky error indication.

Behaviour:
- Reset (reset=0, async): estado=IDLE, data_out=0, valid_out=0, enviados=0, error_out=0, read pipeline flag cleared.
  - fifo_read_enable=0 while in reset.
  - Reset mid-transfer discards in-flight words; no valid_out follows.
- fifo_read_enable is combinational: (estado==ACTIVE) && !fifo_empty && (pausa==4'b0000).
- Pipeline:
  - Read issued in cycle N sets rd_pend, registered at edge N→N+1.
  - In cycle N+1, fifo_data_out is valid and rd_pend=1.
  - At edge N+1→N+2, data_out<=fifo_data_out; valid_out<=one-hot(fifo_data_out[MSB:MSB-1]) if rd_pend, else 0.
  - Net latency: read_enable to valid_out = 2 edges; sustained throughput 1 word/cycle.
- valid_out is a 1-cycle pulse per word. data_out holds its last value when valid_out=0.
- enviados increments by 1 on every cycle valid_out!=0 and wraps from 2^ancho_contador-1 to 0.
- FSM transitions (registered):
  - IDLE→ACTIVE: !fifo_empty && pausa==0.
  - ACTIVE→PAUSE: pausa!=0.
  - ACTIVE→IDLE: fifo_empty && pausa==0.
  - PAUSE→ACTIVE: pausa==0 && !fifo_empty.
  - PAUSE→IDLE: pausa==0 && fifo_empty.
  - Any state→ERROR: fifo_error==1; this has priority over every other transition.
  - ERROR is sticky until reset.
- Pause:
  - Any pausa bit blocks the read in the same cycle, since read_enable is combinational.
  - Up to 2 already-issued words still complete.
  - Destination almost_full thresholds must therefore leave ≥2 free slots.
- Entering ERROR:
  - error_out=1 from the next cycle.
  - fifo_read_enable forced 0.
  - A word in flight at the transition is discarded; valid_out stays 0.
  - enviados frozen.
- Empty: no read is issued while fifo_empty=1, so the block never itself causes an upstream underflow.
- Simultaneous pausa rising and fifo_empty: PAUSE takes precedence over IDLE.

Test Plan:
- Reset, then 4 writes 0x000,0x155,0x2AA,0x3FF, pausa=0.
  - Reads issued back-to-back.
  - valid_out = 0001,0010,0100,1000 on consecutive cycles, with data_out matching.
  - enviados=4; estado returns to IDLE (00).
- Stream of 8 words to destination 2 with pausa=0100 asserted for 5 cycles mid-stream.
  - read_enable drops the same cycle; ≤2 further pushes occur; estado=10.
  - After release, the remaining words are delivered in order; total 8 pushes, no duplicates or loss.
- Pulse fifo_error=1 for 1 cycle during streaming.
  - estado=11, error_out=1, read_enable=0.
  - The in-flight word is not pushed; state persists until reset=0, after which all outputs are 0.
- Forward 257 words.
  - enviados wraps 255→0 and reads 1 at the end.
- Assert reset=0 asynchronously (between edges) while rd_pend=1.
  - All outputs clear immediately; no valid_out after release.
  - First new word is forwarded with the normal 2-edge latency.
- fifo_empty=1 with pausa=0 held for 20 cycles.
  - fifo_read_enable never asserts; estado stays 00; valid_out stays 0.
